// File: rtl/mult4u_chk_pkg.sv
// Shared types and helpers for the 4x4 unsigned multiplier checkers.
// mod3_res weights bits 1,2,1,2,... because 2^i mod 3 alternates between 1 and 2.
package mult4u_chk_pkg;

  localparam int A_W = 4;
  localparam int B_W = 4;
  localparam int P_W = 8;

  typedef struct packed {
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic [P_W-1:0] p;
  } chk_word_t;

  function automatic logic [1:0] mod3_res(input logic [7:0] x);
    logic [3:0] evenSum;
    logic [3:0] oddSum;
    logic [4:0] total;
    evenSum = 4'(x[0]) + 4'(x[2]) + 4'(x[4]) + 4'(x[6]);
    oddSum  = 4'(x[1]) + 4'(x[3]) + 4'(x[5]) + 4'(x[7]);
    total   = 5'(evenSum) + {oddSum, 1'b0};
    return 2'(total % 5'd3);
  endfunction

endpackage

// File: rtl/mult4u_mod3_residue.sv
// Combinational mod-3 residue of an 8-bit value; narrower operands are zero-extended by the caller.
module mult4u_mod3_residue
  import mult4u_chk_pkg::*;
(
  input  logic [7:0] i_x,
  output logic [1:0] o_res
);

  assign o_res = mod3_res(i_x);

endmodule

// File: rtl/mult4u_residue_checker.sv
// Two-stage valid/ready checker behind the 4-bit multiplier: stage 1 captures A/B/P,
// stage 2 holds the forwarded product and its error flag. Also keeps error statistics.
module mult4u_residue_checker
  import mult4u_chk_pkg::*;
#(
  parameter int EXACT    = 0,
  parameter int CNT_W    = 8,
  parameter int ALARM_TH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   in_a,
  input  logic [B_W-1:0]   in_b,
  input  logic [P_W-1:0]   in_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [P_W-1:0]   out_p,
  output logic             out_err,
  input  logic             clr_err,
  output logic [CNT_W-1:0] err_count,
  output logic             err_sticky,
  output logic             err_alarm
);

  localparam logic [CNT_W-1:0] ALARM_LVL = CNT_W'(ALARM_TH);

  logic             r_s1_v;
  chk_word_t        r_s1;
  logic             r_s2_v;
  logic [P_W-1:0]   r_out_p;
  logic             r_out_err;
  logic [CNT_W-1:0] r_err_count;
  logic             r_err_sticky;

  logic             w_s2_load;
  logic             w_s1_load;
  logic             w_flagged_xfer;
  logic [1:0]       w_res_a;
  logic [1:0]       w_res_b;
  logic [1:0]       w_res_p;
  logic [3:0]       w_res_prod;
  logic [1:0]       w_res_prod_mod;
  logic [P_W-1:0]   w_prod;
  logic             w_err;

  assign w_s2_load      = !r_s2_v || out_ready;
  assign w_s1_load      = !r_s1_v || w_s2_load;
  assign w_flagged_xfer = r_s2_v && out_ready && r_out_err;

  mult4u_mod3_residue u_res_a (.i_x({{(P_W-A_W){1'b0}}, r_s1.a}), .o_res(w_res_a));
  mult4u_mod3_residue u_res_b (.i_x({{(P_W-B_W){1'b0}}, r_s1.b}), .o_res(w_res_b));
  mult4u_mod3_residue u_res_p (.i_x(r_s1.p),                      .o_res(w_res_p));

  // Both checks are built; EXACT only selects which one drives the flag.
  assign w_res_prod     = {2'b00, w_res_a} * {2'b00, w_res_b};
  assign w_res_prod_mod = 2'(w_res_prod % 4'd3);
  assign w_prod         = {{(P_W-A_W){1'b0}}, r_s1.a} * {{(P_W-B_W){1'b0}}, r_s1.b};
  assign w_err          = (EXACT != 0) ? (w_prod != r_s1.p) : (w_res_prod_mod != w_res_p);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v <= 1'b0;
      r_s1   <= '0;
    end else if (w_s1_load) begin
      r_s1_v <= in_valid;
      if (in_valid) begin
        r_s1.a <= in_a;
        r_s1.b <= in_b;
        r_s1.p <= in_p;
      end
    end
  end

  // Output registers only change when a real word moves in, so they hold under stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_v    <= 1'b0;
      r_out_p   <= '0;
      r_out_err <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_out_p   <= r_s1.p;
        r_out_err <= w_err;
      end
    end
  end

  // Clear takes priority but a flagged transfer in the same cycle still counts once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count  <= '0;
      r_err_sticky <= 1'b0;
    end else if (clr_err) begin
      r_err_count  <= w_flagged_xfer ? CNT_W'(1) : '0;
      r_err_sticky <= w_flagged_xfer;
    end else if (w_flagged_xfer) begin
      r_err_sticky <= 1'b1;
      if (r_err_count != '1) begin
        r_err_count <= r_err_count + CNT_W'(1);
      end
    end
  end

  assign in_ready   = w_s1_load;
  assign out_valid  = r_s2_v;
  assign out_p      = r_out_p;
  assign out_err    = r_out_err;
  assign err_count  = r_err_count;
  assign err_sticky = r_err_sticky;
  assign err_alarm  = (r_err_count >= ALARM_LVL);

endmodule

// File: tb/tb_mult4u_residue_checker.sv
// Self-checking bench: a residue-mode checker (CNT_W=4) and an exact-mode checker share one stream.
// A negedge scoreboard checks every output transfer and the error statistics against a reference model.
module tb_mult4u_residue_checker;

  logic       clk;
  logic       rst;
  logic       inValid;
  logic [3:0] inA;
  logic [3:0] inB;
  logic [7:0] inP;
  logic       outReady;
  logic       clrErr;

  logic       inReadyR, outValidR, outErrR, errStickyR, errAlarmR;
  logic [7:0] outPR;
  logic [3:0] errCountR;
  logic       inReadyE, outValidE, outErrE, errStickyE, errAlarmE;
  logic [7:0] outPE;
  logic [7:0] errCountE;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [7:0] p;
    logic       errR;
    logic       errE;
  } expWord_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
    logic       errR;
    logic       errE;
  } vec_t;

  expWord_t sbQueue[$];
  int       mCntR, mCntE;
  logic     mStR, mStE;

  mult4u_residue_checker #(.EXACT(0), .CNT_W(4), .ALARM_TH(4)) dutR (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReadyR),
    .in_a(inA), .in_b(inB), .in_p(inP),
    .out_valid(outValidR), .out_ready(outReady), .out_p(outPR), .out_err(outErrR),
    .clr_err(clrErr), .err_count(errCountR), .err_sticky(errStickyR), .err_alarm(errAlarmR)
  );

  mult4u_residue_checker #(.EXACT(1)) dutE (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReadyE),
    .in_a(inA), .in_b(inB), .in_p(inP),
    .out_valid(outValidE), .out_ready(outReady), .out_p(outPE), .out_err(outErrE),
    .clr_err(clrErr), .err_count(errCountE), .err_sticky(errStickyE), .err_alarm(errAlarmE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic refErrResidue(input logic [3:0] a, input logic [3:0] b, input logic [7:0] p);
    return ((int'(a) * int'(b)) % 3) != (int'(p) % 3);
  endfunction

  function automatic logic refErrExact(input logic [3:0] a, input logic [3:0] b, input logic [7:0] p);
    return (int'(a) * int'(b)) != int'(p);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Drives one word and returns just after the edge that accepts it; in_valid is left high.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic [7:0] p);
    int n;
    inValid = 1'b1;
    inA     = a;
    inB     = b;
    inP     = p;
    n = 0;
    forever begin
      @(negedge clk);
      if (inReadyR && inReadyE) break;
      n++;
      if (n >= 20) begin
        checkOutput("acceptTimeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic waitOutValid();
    int n;
    n = 0;
    while (!outValidR && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!outValidR) checkOutput("outValidTimeout", 0, 1);
  endtask

  // Scoreboard and statistics model, sampled mid-cycle while inputs and outputs are stable.
  always @(negedge clk) begin
    logic     flagR, flagE;
    expWord_t e;
    if (rst) begin
      sbQueue.delete();
      mCntR = 0;
      mCntE = 0;
      mStR  = 1'b0;
      mStE  = 1'b0;
    end else begin
      checkOutput("errCountR", int'(errCountR), mCntR);
      checkOutput("errCountE", int'(errCountE), mCntE);
      checkOutput("errStickyR", int'(errStickyR), int'(mStR));
      checkOutput("errStickyE", int'(errStickyE), int'(mStE));
      checkOutput("errAlarmR", int'(errAlarmR), (mCntR >= 4) ? 1 : 0);
      checkOutput("errAlarmE", int'(errAlarmE), (mCntE >= 4) ? 1 : 0);
      flagR = 1'b0;
      flagE = 1'b0;
      if (outValidR && outReady) begin
        if (sbQueue.size() == 0) begin
          checkOutput("scoreboardUnexpectedWord", int'(outPR), -1);
        end else begin
          e = sbQueue.pop_front();
          checkOutput("sbOutPR", int'(outPR), int'(e.p));
          checkOutput("sbOutErrR", int'(outErrR), int'(e.errR));
          checkOutput("sbOutValidE", int'(outValidE), 1);
          checkOutput("sbOutPE", int'(outPE), int'(e.p));
          checkOutput("sbOutErrE", int'(outErrE), int'(e.errE));
          flagR = e.errR;
          flagE = e.errE;
        end
      end
      if (clrErr) begin
        mCntR = flagR ? 1 : 0;
        mStR  = flagR;
        mCntE = flagE ? 1 : 0;
        mStE  = flagE;
      end else begin
        if (flagR) begin
          mCntR = (mCntR == 15) ? 15 : mCntR + 1;
          mStR  = 1'b1;
        end
        if (flagE) begin
          mCntE = (mCntE == 255) ? 255 : mCntE + 1;
          mStE  = 1'b1;
        end
      end
      if (inValid && inReadyR) begin
        e.p    = inP;
        e.errR = refErrResidue(inA, inB, inP);
        e.errE = refErrExact(inA, inB, inP);
        sbQueue.push_back(e);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[15];
    vecs[0]  = '{4'd7,  4'd9, 8'd63,  1'b0, 1'b0};
    vecs[1]  = '{4'd7,  4'd9, 8'd62,  1'b1, 1'b1};
    vecs[2]  = '{4'd7,  4'd9, 8'd61,  1'b1, 1'b1};
    vecs[3]  = '{4'd7,  4'd9, 8'd59,  1'b1, 1'b1};
    vecs[4]  = '{4'd7,  4'd9, 8'd55,  1'b1, 1'b1};
    vecs[5]  = '{4'd7,  4'd9, 8'd47,  1'b1, 1'b1};
    vecs[6]  = '{4'd7,  4'd9, 8'd31,  1'b1, 1'b1};
    vecs[7]  = '{4'd7,  4'd9, 8'd127, 1'b1, 1'b1};
    vecs[8]  = '{4'd7,  4'd9, 8'd191, 1'b1, 1'b1};
    vecs[9]  = '{4'd7,  4'd9, 8'd60,  1'b0, 1'b1};
    vecs[10] = '{4'd15, 4'd15, 8'd225, 1'b0, 1'b0};
    vecs[11] = '{4'd15, 4'd15, 8'd222, 1'b0, 1'b1};
    vecs[12] = '{4'd0,  4'd0, 8'd0,   1'b0, 1'b0};
    vecs[13] = '{4'd0,  4'd5, 8'd3,   1'b0, 1'b1};
    vecs[14] = '{4'd3,  4'd5, 8'd16,  1'b1, 1'b1};

    rst      = 1'b1;
    inValid  = 1'b0;
    inA      = '0;
    inB      = '0;
    inP      = '0;
    outReady = 1'b1;
    clrErr   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetOutValid", int'(outValidR), 0);
    checkOutput("resetOutP", int'(outPR), 0);
    checkOutput("resetOutErr", int'(outErrR), 0);
    checkOutput("resetErrCount", int'(errCountR), 0);
    checkOutput("resetErrSticky", int'(errStickyR), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("readyAfterReset", int'(inReadyR), 1);

    $display("[TB] latency check");
    inValid = 1'b1;
    inA = 4'd7; inB = 4'd9; inP = 8'd63;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    checkOutput("latencyEdge1OutValid", int'(outValidR), 0);
    @(posedge clk);
    #1;
    checkOutput("latencyEdge2OutValid", int'(outValidR), 1);
    checkOutput("latencyOutP", int'(outPR), 63);
    checkOutput("latencyOutErr", int'(outErrR), 0);
    @(posedge clk);
    #1;

    $display("[TB] table vectors");
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].p);
      inValid = 1'b0;
      waitOutValid();
      checkOutput($sformatf("vec%0d_outP", i), int'(outPR), int'(vecs[i].p));
      checkOutput($sformatf("vec%0d_outErrResidue", i), int'(outErrR), int'(vecs[i].errR));
      checkOutput($sformatf("vec%0d_outErrExact", i), int'(outErrE), int'(vecs[i].errE));
      @(posedge clk);
      #1;
    end

    $display("[TB] backpressure sequence");
    outReady = 1'b0;
    inValid = 1'b1; inA = 4'd1; inB = 4'd2; inP = 8'd2;
    @(posedge clk);
    #1;
    inA = 4'd3; inB = 4'd4; inP = 8'd12;
    @(posedge clk);
    #1;
    inA = 4'd5; inB = 4'd6; inP = 8'd30;
    checkOutput("stallInReady", int'(inReadyR), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("stallOutValid", int'(outValidR), 1);
      checkOutput("stallOutPHeld", int'(outPR), 2);
      checkOutput("stallInReadyHeld", int'(inReadyR), 0);
    end
    outReady = 1'b1;
    #1;
    checkOutput("releaseInReady", int'(inReadyR), 1);
    @(posedge clk);
    #1;
    inValid = 1'b0;
    checkOutput("releaseWord2", int'(outPR), 12);
    @(posedge clk);
    #1;
    checkOutput("releaseWord3", int'(outPR), 30);
    @(posedge clk);
    #1;
    checkOutput("releaseDrained", int'(outValidR), 0);

    $display("[TB] saturation sequence");
    clrErr = 1'b1;
    @(posedge clk);
    #1;
    clrErr = 1'b0;
    checkOutput("clrErrCount", int'(errCountR), 0);
    checkOutput("clrErrSticky", int'(errStickyR), 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(4'd7, 4'd9, 8'd62);
    end
    inValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("satCountResidue", int'(errCountR), 15);
    checkOutput("satCountExact", int'(errCountE), 20);
    checkOutput("satAlarm", int'(errAlarmR), 1);
    applyStimulus(4'd7, 4'd9, 8'd62);
    inValid = 1'b0;
    waitOutValid();
    clrErr = 1'b1;
    @(posedge clk);
    #1;
    clrErr = 1'b0;
    checkOutput("clrWithFlagCountR", int'(errCountR), 1);
    checkOutput("clrWithFlagCountE", int'(errCountE), 1);
    checkOutput("clrWithFlagStickyR", int'(errStickyR), 1);
    checkOutput("clrWithFlagAlarmR", int'(errAlarmR), 0);

    $display("[TB] reset mid-stream");
    outReady = 1'b0;
    applyStimulus(4'd2, 4'd2, 8'd4);
    applyStimulus(4'd2, 4'd3, 8'd7);
    inValid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("preResetOutValid", int'(outValidR), 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncResetOutValid", int'(outValidR), 0);
    checkOutput("asyncResetCountR", int'(errCountR), 0);
    checkOutput("asyncResetCountE", int'(errCountE), 0);
    checkOutput("asyncResetStickyR", int'(errStickyR), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("postResetInReady", int'(inReadyR), 1);
    checkOutput("postResetOutValid", int'(outValidR), 0);
    inValid = 1'b1; inA = 4'd6; inB = 4'd7; inP = 8'd42;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    checkOutput("postResetEdge1OutValid", int'(outValidR), 0);
    @(posedge clk);
    #1;
    checkOutput("postResetEdge2OutValid", int'(outValidR), 1);
    checkOutput("postResetOutP", int'(outPR), 42);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboardEmpty", sbQueue.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
